game_frame_rx: RTL and testbench
================================

// Module: game_frame_rx
// PURPOSE
//  Player-2-board decoder for the game-state stream that the player-1 board serialises over UART.
//  Consumes 16-bit words from the 8-to-16 converter and checks frame order.
//  Publishes player-1 position, ball position, scores and flags atomically, once per complete frame.
//  Sits between the uart block (data_out/conv8to16valid) and the player-2-side draw/score logic.
// PARAMETERS
//  WORD_TIMEOUT  32'd50_000     max clk cycles between words inside a frame before abort
//  LINK_TIMEOUT  32'd6_500_000  clk cycles without a good frame before link_ok drops (100 ms @ 65 MHz)
// PORTS
//  clk             in   1   pixel-domain clock (65 MHz)
//  rst             in   1   asynchronous, active-low reset
//  data            in   16  received word: [15:12] tag, [11:0] payload
//  conv8to16valid  in   1   1-cycle strobe, data valid
//  pl1_posx        out  12  player-1 x position
//  pl1_posy        out  12  player-1 y position
//  ball_posx       out  12  ball x position
//  ball_posy       out  12  ball y position
//  pl1_score       out  4   player-1 score
//  pl2_score       out  4   player-2 score
//  flag_point      out  1   last-touch/point flag
//  end_game        out  1   game-over flag
//  frame_done      out  1   1-cycle pulse, outputs just updated
//  frame_err       out  1   1-cycle pulse, frame discarded
//  link_ok         out  1   high while frames are arriving
// BEHAVIOUR
//  - Reset (rst=0): all data outputs 0; frame_done=0, frame_err=0, link_ok=0; FSM in IDLE.
//  - Tags, in fixed order: 1 PL1X, 2 PL1Y, 3 BALLX, 4 BALLY, 5 STAT.
//  - STAT payload: [11]=flag_point, [10]=end_game, [9:8]=reserved (ignored), [7:4]=pl1_score, [3:0]=pl2_score.
//  - FSM states: IDLE, W_PL1Y, W_BALLX, W_BALLY, W_STAT (+ W_CSUM if enabled).
//    - IDLE: a tag-1 word is stored in shadow -> W_PL1Y. Any other tag is dropped silently.
//    - W_x: the expected tag is stored in shadow and the FSM advances.
//    - Wrong tag in W_x -> frame_err pulse. If that tag is 1, it is stored and the FSM goes to W_PL1Y (resync); otherwise -> IDLE.
//  - Commit: on the valid STAT word, shadow -> outputs on the next clk edge, all fields in the same cycle.
//    frame_done pulses in that same cycle. Latency: STAT strobe edge N -> outputs/frame_done valid after edge N+1.
//  - Word timeout: counter clears on each strobe and counts while FSM != IDLE.
//    On reaching WORD_TIMEOUT -> frame_err pulse, -> IDLE, shadow discarded, outputs hold their last values.
//  - Link watchdog: counter clears on frame_done, saturates at LINK_TIMEOUT.
//    link_ok = 1 from the first frame_done until the counter reaches LINK_TIMEOUT.
//  - Outputs change only on commit; a partial or aborted frame never modifies them.
//  - Simultaneous events: a strobe and the word-timeout threshold in the same cycle -> the strobe wins, counter clears.
//  - Strobes in consecutive cycles are legal and each is processed.
//  - Reset asserted mid-frame: immediate clear to reset values, no pulse emitted.
// CONFIGURATION
//  GAME_RX_CHECKSUM_EN defined:
//    - Adds tag 6 CSUM after STAT; payload = XOR of the five preceding 12-bit payloads.
//    - Commit happens on a matching CSUM word.
//    - Mismatch -> frame_err pulse, -> IDLE, no commit.
//    - Latency is measured from the CSUM strobe.
//  GAME_RX_CHECKSUM_EN undefined: commit on STAT; tag 6 is treated as an unexpected tag.
// STRUCTURE
//  - Shared include _game_link_macros.vh holds:
//    - tag constants GL_TAG_PL1X..GL_TAG_CSUM
//    - STAT bit-field positions
//    - frame length
//  - uart_mux on the player-1 board uses the same include.
//  - One sub-module, link_watchdog: a saturating counter with clear, threshold parameter, expired output.
//    Instantiated twice: word timeout and link timeout.
//  - Rest: FSM, shadow registers, output registers.
// TESTING
//  1. Frame 0x1123,0x2045,0x3200,0x4100,0x5A53
//     -> after STAT: pl1_posx=0x123, pl1_posy=0x045, ball_posx=0x200, ball_posy=0x100,
//        flag_point=1, end_game=0, pl1_score=5, pl2_score=3; frame_done pulses once, link_ok=1.
//  2. Frame 0x1010,0x2020,0x4030 after a good frame
//     -> frame_err pulse on the 0x4030 word, FSM in IDLE, outputs unchanged.
//  3. 0x1111,0x2222, then 0x1333,0x2444,0x3555,0x4666,0x5012
//     -> frame_err on 0x1333 (resync); commit with pl1_posx=0x333, pl1_posy=0x444.
//  4. 0x1111 followed by WORD_TIMEOUT idle cycles (WORD_TIMEOUT=100 in bench)
//     -> frame_err pulse at cycle 100; next full frame commits normally.
//  5. LINK_TIMEOUT=1000: one good frame, then silence
//     -> link_ok falls 1000 cycles after frame_done; next good frame raises it again.
//  6. GAME_RX_CHECKSUM_EN defined: frame from scenario 1 plus CSUM 0x6,(XOR of the five payloads)
//     -> commit. The same frame with CSUM payload^1 -> frame_err, no commit.
//  - Every scenario also applies rst=0 mid-frame once and checks that all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/game_frame_rx_pkg.sv
// game_frame_rx_pkg: link tags, STAT field positions, frame length and FSM states; GAME_RX_CHECKSUM_EN adds the CSUM word
package game_frame_rx_pkg;
  localparam logic [3:0] GL_TAG_PL1X  = 4'd1;
  localparam logic [3:0] GL_TAG_PL1Y  = 4'd2;
  localparam logic [3:0] GL_TAG_BALLX = 4'd3;
  localparam logic [3:0] GL_TAG_BALLY = 4'd4;
  localparam logic [3:0] GL_TAG_STAT  = 4'd5;
  localparam logic [3:0] GL_TAG_CSUM  = 4'd6;
  localparam int GL_STAT_FLAG = 11;
  localparam int GL_STAT_END  = 10;
  localparam int GL_STAT_S1   = 4;
  localparam int GL_STAT_S2   = 0;
`ifdef GAME_RX_CHECKSUM_EN
  localparam int GL_FRAME_LEN = 6;
`else
  localparam int GL_FRAME_LEN = 5;
`endif
  typedef enum logic [2:0] {IDLE, W_PL1Y, W_BALLX, W_BALLY, W_STAT, W_CSUM} state_t;
  function automatic logic [3:0] exp_tag(input state_t s);
    return {1'b0, s} + 4'd1;
  endfunction
endpackage

// File: rtl/game_frame_rx_link_watchdog.sv
// link_watchdog: saturating cycle counter with clear; expired while the count sits at LIMIT
module link_watchdog #(
  parameter logic [31:0] LIMIT = 32'd1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [31:0] count_q, count_d;
  // clear has priority over counting; counting stops at LIMIT
  always_comb count_d = clr ? '0 : (en && count_q != LIMIT) ? count_q + 32'd1 : count_q;
  // count register, async active-low reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) count_q <= '0;
    else count_q <= count_d;
  assign expired = count_q == LIMIT;
endmodule

// File: rtl/game_frame_rx.sv
// game_frame_rx: checks tag order of game-state words and commits a full frame atomically; GAME_RX_CHECKSUM_EN adds a CSUM word
module game_frame_rx
  import game_frame_rx_pkg::*;
#(
  parameter logic [31:0] WORD_TIMEOUT = 32'd50_000,
  parameter logic [31:0] LINK_TIMEOUT = 32'd6_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic        conv8to16valid,
  output logic [11:0] pl1_posx,
  output logic [11:0] pl1_posy,
  output logic [11:0] ball_posx,
  output logic [11:0] ball_posy,
  output logic [3:0]  pl1_score,
  output logic [3:0]  pl2_score,
  output logic        flag_point,
  output logic        end_game,
  output logic        frame_done,
  output logic        frame_err,
  output logic        link_ok
);
  localparam state_t LAST = state_t'(GL_FRAME_LEN - 1);
  state_t state_q, state_d;
  logic [11:0] sh_pl1x_q, sh_pl1x_d, sh_pl1y_q, sh_pl1y_d, sh_ballx_q, sh_ballx_d, sh_bally_q, sh_bally_d;
  logic [11:0] pl1x_q, pl1x_d, pl1y_q, pl1y_d, ballx_q, ballx_d, bally_q, bally_d;
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic flag_q, flag_d, end_q, end_d, done_q, done_d, err_q, err_d, seen_q, seen_d;
  logic [3:0] tag;
  logic [11:0] pay, fin_stat;
  logic idle, commit_ok, word_exp, link_exp;
  assign tag = data[15:12];
  assign pay = data[11:0];
  assign idle = state_q == IDLE;
`ifdef GAME_RX_CHECKSUM_EN
  logic [11:0] sh_stat_q, sh_stat_d;
  assign fin_stat = sh_stat_q;
  assign commit_ok = pay == (sh_pl1x_q ^ sh_pl1y_q ^ sh_ballx_q ^ sh_bally_q ^ sh_stat_q);
  // STAT is held back until the checksum word confirms the frame
  always_comb sh_stat_d = (conv8to16valid && state_q == W_STAT && tag == GL_TAG_STAT) ? pay : sh_stat_q;
  // STAT shadow register
  always_ff @(posedge clk or negedge rst)
    if (!rst) sh_stat_q <= '0;
    else sh_stat_q <= sh_stat_d;
`else
  assign fin_stat = pay;
  assign commit_ok = 1'b1;
`endif
  // the word timer only runs inside a frame; any strobe restarts it
  link_watchdog #(.LIMIT(WORD_TIMEOUT - 32'd1)) u_word_wd (
    .clk(clk), .rst(rst), .clr(conv8to16valid | idle), .en(!idle), .expired(word_exp)
  );
  // the link timer restarts on every commit
  link_watchdog #(.LIMIT(LINK_TIMEOUT)) u_link_wd (
    .clk(clk), .rst(rst), .clr(done_d), .en(1'b1), .expired(link_exp)
  );
  // frame FSM: shadow capture, resync on tag 1, commit on the last word, abort on timeout
  always_comb begin
    state_d = state_q;
    sh_pl1x_d = sh_pl1x_q;
    sh_pl1y_d = sh_pl1y_q;
    sh_ballx_d = sh_ballx_q;
    sh_bally_d = sh_bally_q;
    pl1x_d = pl1x_q;
    pl1y_d = pl1y_q;
    ballx_d = ballx_q;
    bally_d = bally_q;
    s1_d = s1_q;
    s2_d = s2_q;
    flag_d = flag_q;
    end_d = end_q;
    seen_d = seen_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (conv8to16valid && tag == exp_tag(state_q)) begin
      state_d = state_t'(state_q + 3'd1);
      sh_pl1x_d = idle ? pay : sh_pl1x_q;
      sh_pl1y_d = state_q == W_PL1Y ? pay : sh_pl1y_q;
      sh_ballx_d = state_q == W_BALLX ? pay : sh_ballx_q;
      sh_bally_d = state_q == W_BALLY ? pay : sh_bally_q;
      if (state_q == LAST) begin
        state_d = IDLE;
        done_d = commit_ok;
        err_d = !commit_ok;
        if (commit_ok) begin
          pl1x_d = sh_pl1x_q;
          pl1y_d = sh_pl1y_q;
          ballx_d = sh_ballx_q;
          bally_d = sh_bally_q;
          flag_d = fin_stat[GL_STAT_FLAG];
          end_d = fin_stat[GL_STAT_END];
          s1_d = fin_stat[GL_STAT_S1 +: 4];
          s2_d = fin_stat[GL_STAT_S2 +: 4];
          seen_d = 1'b1;
        end
      end
    end else if (conv8to16valid && !idle) begin
      err_d = 1'b1;
      state_d = tag == GL_TAG_PL1X ? W_PL1Y : IDLE;
      sh_pl1x_d = tag == GL_TAG_PL1X ? pay : sh_pl1x_q;
    end else if (!idle && word_exp) begin
      err_d = 1'b1;
      state_d = IDLE;
    end
  end
  // state, shadow and published registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      sh_pl1x_q <= '0;
      sh_pl1y_q <= '0;
      sh_ballx_q <= '0;
      sh_bally_q <= '0;
      pl1x_q <= '0;
      pl1y_q <= '0;
      ballx_q <= '0;
      bally_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      flag_q <= 1'b0;
      end_q <= 1'b0;
      seen_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_pl1x_q <= sh_pl1x_d;
      sh_pl1y_q <= sh_pl1y_d;
      sh_ballx_q <= sh_ballx_d;
      sh_bally_q <= sh_bally_d;
      pl1x_q <= pl1x_d;
      pl1y_q <= pl1y_d;
      ballx_q <= ballx_d;
      bally_q <= bally_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      flag_q <= flag_d;
      end_q <= end_d;
      seen_q <= seen_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign pl1_posx = pl1x_q;
  assign pl1_posy = pl1y_q;
  assign ball_posx = ballx_q;
  assign ball_posy = bally_q;
  assign pl1_score = s1_q;
  assign pl2_score = s2_q;
  assign flag_point = flag_q;
  assign end_game = end_q;
  assign frame_done = done_q;
  assign frame_err = err_q;
  assign link_ok = seen_q & !link_exp;
endmodule

// File: tb/tb_game_frame_rx.sv
// tb_game_frame_rx: scoreboard bench for game_frame_rx (WORD_TIMEOUT=100, LINK_TIMEOUT=1000)
`timescale 1ns/1ps
module tb_game_frame_rx;
  typedef struct packed {
    logic [11:0] px, py, bx, by;
    logic [3:0] s1, s2;
    logic fp, eg;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0;
  logic [15:0] data = '0;
  logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
  logic [3:0] pl1_score, pl2_score;
  logic flag_point, end_game, frame_done, frame_err, link_ok;
  exp_t obs, last = '0;
  exp_t q_exp[$];
  logic [15:0] tx[$];
  int total = 0, bad = 0, n_err = 0, n_done = 0;
  always #5 clk = ~clk;
  game_frame_rx #(.WORD_TIMEOUT(32'd100), .LINK_TIMEOUT(32'd1000)) dut (
    .clk(clk), .rst(rst), .data(data), .conv8to16valid(valid),
    .pl1_posx(pl1_posx), .pl1_posy(pl1_posy), .ball_posx(ball_posx), .ball_posy(ball_posy),
    .pl1_score(pl1_score), .pl2_score(pl2_score), .flag_point(flag_point), .end_game(end_game),
    .frame_done(frame_done), .frame_err(frame_err), .link_ok(link_ok)
  );
  assign obs = {pl1_posx, pl1_posy, ball_posx, ball_posy, pl1_score, pl2_score, flag_point, end_game};
  task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // scoreboard: every frame_done pops the next expected commit
  always @(negedge clk)
    if (rst) begin
      if (frame_err) n_err++;
      if (frame_done) begin
        n_done++;
        if (q_exp.size() == 0) chk("unexp_done", frame_done, 0);
        else begin
          last = q_exp.pop_front();
          chk("commit", obs, last);
        end
      end
    end
  task burst();
    foreach (tx[i]) begin
      @(negedge clk);
      data = tx[i];
      valid = 1'b1;
    end
    @(negedge clk);
    valid = 1'b0;
    #1;
    tx.delete();
  endtask
`ifdef GAME_RX_CHECKSUM_EN
  function automatic logic [11:0] csum(input logic [15:0] a, b, c, d, e);
    logic [15:0] x;
    x = a ^ b ^ c ^ d ^ e;
    return x[11:0];
  endfunction
`endif
  task frame(input logic [15:0] a, b, c, d, e);
    tx = '{a, b, c, d, e};
`ifdef GAME_RX_CHECKSUM_EN
    tx.push_back({4'h6, csum(a, b, c, d, e)});
`endif
    burst();
  endtask
  task automatic good_frame(input logic [15:0] a, b, c, d, e, input exp_t x);
    int d0 = n_done;
    q_exp.push_back(x);
    frame(a, b, c, d, e);
    chk("done_lat", frame_done, 1);
    chk("link_up", link_ok, 1);
    @(negedge clk);
    #1;
    chk("done_pulse", frame_done, 0);
    chk("done_cnt", n_done, d0 + 1);
  endtask
  task automatic mid_reset();
    int e0 = n_err;
    tx = '{16'h1777, 16'h2888};
    burst();
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_outs", obs, 0);
    chk("rst_flags", {frame_done, frame_err, link_ok}, 0);
    @(negedge clk);
    rst = 1'b1;
    last = '0;
    chk("rst_no_err", n_err, e0);
  endtask
  initial begin
    int k, e0;
    #2 rst = 1'b0;
    #1;
    chk("reset_outs", obs, 0);
    chk("reset_flags", {frame_done, frame_err, link_ok}, 0);
    @(negedge clk);
    rst = 1'b1;
    good_frame(16'h1123, 16'h2045, 16'h3200, 16'h4100, 16'h5A53,
               '{12'h123, 12'h045, 12'h200, 12'h100, 4'd5, 4'd3, 1'b1, 1'b0});
    e0 = n_err;
    tx = '{16'h1010, 16'h2020, 16'h4030};
    burst();
    chk("s2_err_pulse", frame_err, 1);
    chk("s2_err_cnt", n_err, e0 + 1);
    chk("s2_hold", obs, last);
    tx = '{16'h2777};
    burst();
    chk("s2_idle_drop", n_err, e0 + 1);
    chk("s2_idle_hold", obs, last);
    mid_reset();
    e0 = n_err;
    tx = '{16'h1111, 16'h2222};
    burst();
    good_frame(16'h1333, 16'h2444, 16'h3555, 16'h4666, 16'h5012,
               '{12'h333, 12'h444, 12'h555, 12'h666, 4'd1, 4'd2, 1'b0, 1'b0});
    chk("s3_resync_err", n_err, e0 + 1);
    e0 = n_err;
    tx = '{16'h1111};
    burst();
    k = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (frame_err) begin
        k = i;
        break;
      end
    end
    chk("s4_timeout_cyc", k, 100);
    #1;
    chk("s4_err_cnt", n_err, e0 + 1);
    chk("s4_hold", obs, last);
    good_frame(16'h1ABC, 16'h2DEF, 16'h3012, 16'h4345, 16'h5C9A,
               '{12'hABC, 12'hDEF, 12'h012, 12'h345, 4'h9, 4'hA, 1'b1, 1'b1});
    k = 0;
    for (int i = 2; i <= 2000; i++) begin
      @(negedge clk);
      if (!link_ok) begin
        k = i;
        break;
      end
    end
    chk("s5_link_drop", k, 1000);
    good_frame(16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5FFF,
               '{12'h001, 12'h002, 12'h003, 12'h004, 4'hF, 4'hF, 1'b1, 1'b1});
    mid_reset();
    e0 = n_err;
`ifdef GAME_RX_CHECKSUM_EN
    good_frame(16'h1123, 16'h2045, 16'h3200, 16'h4100, 16'h5A53,
               '{12'h123, 12'h045, 12'h200, 12'h100, 4'd5, 4'd3, 1'b1, 1'b0});
    k = n_done;
    tx = '{16'h1555, 16'h2045, 16'h3200, 16'h4100, 16'h5A53,
           {4'h6, csum(16'h1555, 16'h2045, 16'h3200, 16'h4100, 16'h5A53) ^ 12'h001}};
    burst();
    chk("s6_bad_csum_err", frame_err, 1);
    chk("s6_no_commit", n_done, k);
    chk("s6_hold", obs, last);
    chk("s6_err_cnt", n_err, e0 + 1);
`else
    tx = '{16'h1111, 16'h2222, 16'h6333};
    burst();
    chk("s6_tag6_err", frame_err, 1);
    tx = '{16'h6444};
    burst();
    chk("s6_tag6_idle", n_err, e0 + 1);
    chk("s6_hold", obs, last);
    good_frame(16'h1123, 16'h2045, 16'h3200, 16'h4100, 16'h5A53,
               '{12'h123, 12'h045, 12'h200, 12'h100, 4'd5, 4'd3, 1'b1, 1'b0});
`endif
    chk("sb_empty", q_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
